// File: rtl/umul_job_sched.sv
// Two-requester job scheduler for a shared rep_uMUL: arbitrates, streams A in unary, counts product ones.
// Optional zero-operand bypass is enabled by defining UMUL_JOB_SCHED_ZBYPASS_EN.
module umul_job_sched #(
    parameter int BITWIDTH = 8,
    parameter int MUL_LAT  = 0
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [1:0]          iReqVld,
    input  logic [BITWIDTH-1:0] iReqA0,
    input  logic [BITWIDTH-1:0] iReqB0,
    input  logic [BITWIDTH-1:0] iReqA1,
    input  logic [BITWIDTH-1:0] iReqB1,
    output logic [1:0]          oReqRdy,
    input  logic [BITWIDTH-1:0] iSobol,
    output logic                oA,
    output logic [BITWIDTH-1:0] oB,
    output logic                oLoadB,
    output logic                oClr,
    input  logic                iMult,
    output logic                oResVld,
    output logic [BITWIDTH-1:0] oRes,
    output logic                oResId,
    input  logic                iResRdy
);
    localparam int BW = BITWIDTH;
    localparam int CW = BW + 2;
    // oA is registered, so the first mult sample arrives one cycle after the counter starts.
    localparam logic [CW-1:0] SAMPLE_FIRST = CW'(1 + MUL_LAT);
    localparam logic [CW-1:0] STREAM_END   = CW'(2 ** BW);
    localparam logic [CW-1:0] RUN_LAST     = CW'(2 ** BW + MUL_LAT);
    localparam logic [BW:0]   ACC_FULL     = {1'b1, {BW{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      rdy_q, rdy_d;
    logic            gnt_id_q, gnt_id_d;
    logic            last_q, last_d;
    logic [BW-1:0]   a_q, a_d;
    logic [BW-1:0]   b_q, b_d;
    logic            id_q, id_d;
    logic            loadb_q, loadb_d;
    logic            clr_q, clr_d;
    logic            oa_q, oa_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW:0]     acc_q, acc_d;
    logic            resvld_q, resvld_d;
    logic [BW-1:0]   res_q, res_d;

    function automatic logic pick(input logic [1:0] vld, input logic last);
        if (vld == 2'b11) return ~last;
        return vld[1];
    endfunction

    always_comb begin
        state_d  = state_q;
        rdy_d    = 2'b00;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        loadb_d  = 1'b0;
        clr_d    = clr_q;
        oa_d     = 1'b0;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        resvld_d = resvld_q;
        res_d    = res_q;
        case (state_q)
            S_IDLE: begin
                clr_d = 1'b1;
                if (rdy_q != 2'b00) begin
                    // A requester that dropped valid during its offer cycle is simply passed over.
                    if ((iReqVld & rdy_q) != 2'b00) begin
                        a_d     = gnt_id_q ? iReqA1 : iReqA0;
                        b_d     = gnt_id_q ? iReqB1 : iReqB0;
                        id_d    = gnt_id_q;
                        last_d  = gnt_id_q;
                        loadb_d = 1'b1;
                        state_d = S_LOAD;
                    end
                end else if (iReqVld != 2'b00) begin
                    gnt_id_d = pick(iReqVld, last_q);
                    rdy_d    = gnt_id_d ? 2'b10 : 2'b01;
                end
            end
            S_LOAD: begin
                cnt_d = '0;
                acc_d = '0;
`ifdef UMUL_JOB_SCHED_ZBYPASS_EN
                if (a_q == '0 || b_q == '0) begin
                    state_d  = S_DONE;
                    clr_d    = 1'b1;
                    resvld_d = 1'b1;
                    res_d    = '0;
                end else begin
                    state_d = S_RUN;
                    clr_d   = 1'b0;
                end
`else
                state_d = S_RUN;
                clr_d   = 1'b0;
`endif
            end
            S_RUN: begin
                clr_d = 1'b0;
                if (cnt_q < STREAM_END) oa_d = (a_q > iSobol);
                if (cnt_q >= SAMPLE_FIRST && iMult) acc_d = acc_q + 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RUN_LAST) begin
                    state_d  = S_DONE;
                    clr_d    = 1'b1;
                    resvld_d = 1'b1;
                    res_d    = (acc_d == ACC_FULL) ? {BW{1'b1}} : acc_d[BW-1:0];
                end
            end
            S_DONE: begin
                clr_d = 1'b1;
                if (iResRdy) begin
                    resvld_d = 1'b0;
                    state_d  = S_IDLE;
                    // Offer the next job straight away so it is visible the cycle after the handshake.
                    if (iReqVld != 2'b00) begin
                        gnt_id_d = pick(iReqVld, last_q);
                        rdy_d    = gnt_id_d ? 2'b10 : 2'b01;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= S_IDLE;
            rdy_q    <= 2'b00;
            gnt_id_q <= 1'b0;
            last_q   <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            loadb_q  <= 1'b0;
            clr_q    <= 1'b1;
            oa_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            resvld_q <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            loadb_q  <= loadb_d;
            clr_q    <= clr_d;
            oa_q     <= oa_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            resvld_q <= resvld_d;
            res_q    <= res_d;
        end
    end

    assign oReqRdy = rdy_q;
    assign oA      = oa_q;
    assign oB      = b_q;
    assign oLoadB  = loadb_q;
    assign oClr    = clr_q;
    assign oResVld = resvld_q;
    assign oRes    = res_q;
    assign oResId  = id_q;

endmodule

// File: tb/tb_umul_job_sched.sv
// Directed bench for umul_job_sched: models sobolrng (bit-reversed counter) and rep_uMUL with a linear B stream.
module tb_umul_job_sched;
    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic [1:0] iReqVld = 2'b00;
    logic [7:0] iReqA0 = 8'd0, iReqB0 = 8'd0, iReqA1 = 8'd0, iReqB1 = 8'd0;
    logic [1:0] oReqRdy;
    logic [7:0] iSobol;
    logic       oA;
    logic [7:0] oB;
    logic       oLoadB, oClr, iMult, oResVld, oResId;
    logic [7:0] oRes;
    logic       iResRdy = 1'b0;
    logic       force_ones = 1'b0;

    localparam int ZLAT =
`ifdef UMUL_JOB_SCHED_ZBYPASS_EN
        2;
`else
        259;
`endif

    umul_job_sched #(.BITWIDTH(8), .MUL_LAT(0)) dut (
        .iClk(iClk), .iRst(iRst), .iReqVld(iReqVld),
        .iReqA0(iReqA0), .iReqB0(iReqB0), .iReqA1(iReqA1), .iReqB1(iReqB1),
        .oReqRdy(oReqRdy), .iSobol(iSobol), .oA(oA), .oB(oB), .oLoadB(oLoadB),
        .oClr(oClr), .iMult(iMult), .oResVld(oResVld), .oRes(oRes),
        .oResId(oResId), .iResRdy(iResRdy)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    logic [7:0] sidx_q = 8'd0;
    logic [7:0] prev_q = 8'd0;
    always @(posedge iClk) begin
        if (oClr) sidx_q <= 8'd0;
        else      sidx_q <= sidx_q + 8'd1;
        prev_q <= sidx_q;
    end

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    assign iSobol = bitrev8(sidx_q);
    assign iMult  = force_ones | (oA & (oB > prev_q));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input logic [1:0] exp_rdy, output int t);
        int n = 0;
        while (oReqRdy == 2'b00 && n < 10) begin
            @(negedge iClk);
            n++;
        end
        chk("grant_onehot", {30'd0, oReqRdy}, {30'd0, exp_rdy});
        t = cyc;
    endtask

    task automatic wait_result(input int t0, input int exp_lat, input int exp_res, input int exp_id);
        int n = 0;
        while (!oResVld && n < 400) begin
            @(negedge iClk);
            n++;
        end
        chk("latency", cyc - t0, exp_lat);
        chk("res", {24'd0, oRes}, exp_res);
        chk("res_id", {31'd0, oResId}, exp_id);
        $display("job id=%0d res=%0d latency=%0d", oResId, oRes, cyc - t0);
    endtask

    task automatic accept_result();
        iResRdy = 1'b1;
        @(negedge iClk);
        iResRdy = 1'b0;
        chk("resvld_drop", {31'd0, oResVld}, 0);
    endtask

    task automatic single_job(input logic id, input logic [7:0] a, input logic [7:0] b,
                              input int exp_res, input int exp_lat);
        int t;
        if (id) begin iReqA1 = a; iReqB1 = b; iReqVld = 2'b10; end
        else    begin iReqA0 = a; iReqB0 = b; iReqVld = 2'b01; end
        wait_grant(id ? 2'b10 : 2'b01, t);
        @(posedge iClk);
        #1 iReqVld = 2'b00;
        @(negedge iClk);
        chk("loadb", {31'd0, oLoadB}, 1);
        chk("ob_latched", {24'd0, oB}, {24'd0, b});
        chk("rdy_one_cycle", {30'd0, oReqRdy}, 0);
        wait_result(t, exp_lat, exp_res, {31'd0, id});
        accept_result();
    endtask

    initial begin
        int t, h;
        logic saw;
        repeat (3) @(negedge iClk);
        chk("rst_rdy", {30'd0, oReqRdy}, 0);
        chk("rst_clr", {31'd0, oClr}, 1);
        chk("rst_resvld", {31'd0, oResVld}, 0);
        chk("rst_res", {24'd0, oRes}, 0);
        chk("rst_resid", {31'd0, oResId}, 0);
        chk("rst_a", {31'd0, oA}, 0);
        chk("rst_b", {24'd0, oB}, 0);
        chk("rst_loadb", {31'd0, oLoadB}, 0);
        iRst = 1'b0;

        single_job(1'b0, 8'd128, 8'd255, 128, 259);
        single_job(1'b1, 8'd0,   8'd200, 0,   ZLAT);
        single_job(1'b0, 8'd100, 8'd128, 50,  259);
        single_job(1'b1, 8'd255, 8'd255, 255, 259);
        force_ones = 1'b1;
        single_job(1'b0, 8'd255, 8'd255, 255, 259);
        force_ones = 1'b0;

        // Abort a job at RUN counter 100.
        iReqA0 = 8'd255; iReqB0 = 8'd255; iReqVld = 2'b01;
        wait_grant(2'b01, t);
        @(posedge iClk);
        #1 iReqVld = 2'b00;
        while (cyc < t + 102) @(negedge iClk);
        chk("run_clr_low", {31'd0, oClr}, 0);
        iRst = 1'b1;
        @(negedge iClk);
        chk("abort_clr", {31'd0, oClr}, 1);
        chk("abort_resvld", {31'd0, oResVld}, 0);
        chk("abort_a", {31'd0, oA}, 0);
        chk("abort_b", {24'd0, oB}, 0);
        chk("abort_rdy", {30'd0, oReqRdy}, 0);
        iRst = 1'b0;
        saw = 1'b0;
        repeat (300) begin
            @(negedge iClk);
            if (oResVld) saw = 1'b1;
        end
        chk("no_result_after_abort", {31'd0, saw}, 0);
        $display("abort done saw_result=%0d", saw);

        // Both requesters held: round-robin from req0.
        iReqA0 = 8'd128; iReqB0 = 8'd255;
        iReqA1 = 8'd100; iReqB1 = 8'd128;
        iReqVld = 2'b11;
        h = 0;
        for (int j = 0; j < 3; j++) begin
            wait_grant((j == 1) ? 2'b10 : 2'b01, t);
            if (j > 0) chk("next_grant_delay", t - h, 1);
            if (j == 2) begin
                @(posedge iClk);
                #1 iReqVld = 2'b00;
            end
            wait_result(t, 259, (j == 1) ? 50 : 128, (j == 1) ? 1 : 0);
            if (j == 0) begin
                repeat (20) begin
                    @(negedge iClk);
                    chk("hold_resvld", {31'd0, oResVld}, 1);
                    chk("hold_res", {24'd0, oRes}, 128);
                    chk("hold_resid", {31'd0, oResId}, 0);
                    chk("hold_rdy", {30'd0, oReqRdy}, 0);
                    chk("hold_clr", {31'd0, oClr}, 1);
                end
            end
            h = cyc;
            accept_result();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
